// File: rtl/rails_pkg.sv
// Shared types and helpers for the rail-station permutation checker.
package rails_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  localparam int unsigned MASK_MAX = 64;

  function automatic int unsigned dw_for(input int unsigned max_trains);
    return $clog2(max_trains + 1);
  endfunction

  // Contiguous run of ones covering bit positions lo..hi-1 (empty when lo == hi).
  function automatic logic [MASK_MAX-1:0] range_mask(input int unsigned lo,
                                                      input int unsigned hi);
    logic [MASK_MAX-1:0] one;
    one = MASK_MAX'(1);
    return (one << hi) - (one << lo);
  endfunction

endpackage

// File: rtl/rails_top_finder.sv
// Highest-set-bit encoder: reports the car number at the top of the station.
module rails_top_finder
  import rails_pkg::*;
#(
  parameter int unsigned W  = 10,
  parameter int unsigned DW = dw_for(W)
) (
  input  logic [W-1:0]  mask_i,
  output logic [DW-1:0] top_o,
  output logic          empty_o
);

  always_comb begin
    top_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (mask_i[i]) top_o = DW'(i + 1);
    end
  end

  assign empty_o = ~|mask_i;

endmodule

// File: rtl/rails_stack_checker.sv
// Streaming rail-station permutation checker with capacity limit, stall
// handshake, range/duplicate detection and peak-occupancy report.
module rails_stack_checker
  import rails_pkg::*;
#(
  parameter int unsigned MAX_TRAINS    = 10,
  parameter int unsigned DW            = dw_for(MAX_TRAINS),
  parameter int unsigned STATION_DEPTH = MAX_TRAINS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] data,
  output logic          valid,
  output logic          result,
  output logic [DW-1:0] peak_depth
);

  localparam logic [DW:0]           CAP_W   = (DW+1)'(STATION_DEPTH);
  localparam logic [DW-1:0]         MAX_N   = DW'(MAX_TRAINS);
  localparam logic [MAX_TRAINS-1:0] ONE_CAR = MAX_TRAINS'(1);

  state_e                state_q;
  logic [DW-1:0]         n_q, cnt_q, depth_q, peak_q;
  logic [DW:0]           next_in_q;
  logic                  fail_q;
  logic [MAX_TRAINS-1:0] station_q, departed_q;
  logic                  valid_q, result_q;
  logic [DW-1:0]         peak_out_q;

  logic [DW-1:0]         depth_d, peak_d;
  logic [DW:0]           next_in_d;
  logic                  fail_d;
  logic [MAX_TRAINS-1:0] station_d, departed_d;

  logic [DW-1:0]         top;
  logic                  empty;
  logic [DW-1:0]         car_m1;
  logic [MAX_TRAINS-1:0] car_bit, push_mask;
  logic [MASK_MAX-1:0]   push_full;
  logic [DW:0]           push_depth;
  logic                  car_fail, do_push, do_pop, last_beat;

  rails_top_finder #(
    .W  (MAX_TRAINS),
    .DW (DW)
  ) u_top (
    .mask_i  (station_q),
    .top_o   (top),
    .empty_o (empty)
  );

  // car 0 wraps car_m1 to all-ones, shifting the bit out so car_bit is zero
  assign car_m1     = data - DW'(1);
  assign car_bit    = ONE_CAR << car_m1;
  assign push_full  = range_mask(int'(next_in_q) - 1, int'(data) - 1);
  assign push_mask  = push_full[MAX_TRAINS-1:0];
  assign push_depth = {1'b0, depth_q} + ({1'b0, data} - next_in_q);
  assign last_beat  = (cnt_q + DW'(1)) == n_q;

  always_comb begin
    car_fail = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    if (data == '0 || data > n_q || |(departed_q & car_bit)) begin
      car_fail = 1'b1;
    end else if ({1'b0, data} >= next_in_q) begin
      do_push = 1'b1;
      if (push_depth > CAP_W) car_fail = 1'b1;
    end else if (!empty && data == top) begin
      do_pop = 1'b1;
    end else begin
      car_fail = 1'b1;
    end
  end

  // Once failed, the sequence state freezes; only the beat counter advances.
  always_comb begin
    fail_d     = fail_q;
    depth_d    = depth_q;
    peak_d     = peak_q;
    next_in_d  = next_in_q;
    station_d  = station_q;
    departed_d = departed_q;
    if (!fail_q) begin
      fail_d = car_fail;
      if (do_push) begin
        station_d  = station_q | push_mask;
        departed_d = departed_q | car_bit;
        depth_d    = push_depth[DW-1:0];
        next_in_d  = {1'b0, data} + (DW+1)'(1);
        if (push_depth[DW-1:0] > peak_q) peak_d = push_depth[DW-1:0];
      end else if (do_pop) begin
        station_d  = station_q & ~car_bit;
        departed_d = departed_q | car_bit;
        depth_d    = depth_q - DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      cnt_q      <= '0;
      depth_q    <= '0;
      peak_q     <= '0;
      next_in_q  <= '0;
      fail_q     <= 1'b0;
      station_q  <= '0;
      departed_q <= '0;
      valid_q    <= 1'b0;
      result_q   <= 1'b0;
      peak_out_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            n_q <= data;
            if (data > MAX_N) begin
              valid_q    <= 1'b1;
              result_q   <= 1'b0;
              peak_out_q <= '0;
            end else if (data != '0) begin
              state_q    <= RUN;
              next_in_q  <= (DW+1)'(1);
              cnt_q      <= '0;
              fail_q     <= 1'b0;
              depth_q    <= '0;
              peak_q     <= '0;
              station_q  <= '0;
              departed_q <= '0;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            cnt_q      <= cnt_q + DW'(1);
            fail_q     <= fail_d;
            depth_q    <= depth_d;
            peak_q     <= peak_d;
            next_in_q  <= next_in_d;
            station_q  <= station_d;
            departed_q <= departed_d;
            if (last_beat) begin
              state_q    <= IDLE;
              valid_q    <= 1'b1;
              result_q   <= !fail_d;
              peak_out_q <= peak_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid      = valid_q;
  assign result     = result_q;
  assign peak_depth = peak_out_q;

endmodule

// File: tb/tb_rails_stack_checker.sv
// Scoreboard bench: driver queues hand-computed verdicts, negedge monitor compares.
module tb_rails_stack_checker;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          iv0, iv1;
  logic [DW-1:0] d0, d1;
  logic          valid0, result0, valid1, result1;
  logic [DW-1:0] peak0, peak1;

  always #5 clk = ~clk;

  rails_stack_checker #(
    .MAX_TRAINS (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (iv0),
    .data       (d0),
    .valid      (valid0),
    .result     (result0),
    .peak_depth (peak0)
  );

  rails_stack_checker #(
    .MAX_TRAINS    (10),
    .STATION_DEPTH (2)
  ) dut_shallow (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (iv1),
    .data       (d1),
    .valid      (valid1),
    .result     (result1),
    .peak_depth (peak1)
  );

  typedef struct {
    logic   res;
    int     peak;
    longint due;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  longint cyc = 0;
  int     compared = 0;
  int     mismatched = 0;
  logic   held_r[2];
  int     held_p[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic mon(input int idx, input logic v, input logic r, input int p);
    exp_t  e;
    string tag;
    int    pending;
    tag     = (idx == 0) ? "main" : "shallow";
    pending = (idx == 0) ? q0.size() : q1.size();
    if (reset) begin
      held_r[idx] = 1'b0;
      held_p[idx] = 0;
      check({tag, ".reset_valid"}, v, 0);
      check({tag, ".reset_result"}, r, 0);
      check({tag, ".reset_peak"}, p, 0);
    end else if (v) begin
      if (pending == 0) begin
        check({tag, ".spurious_valid"}, 1, 0);
      end else begin
        if (idx == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        check({tag, ".latency"}, cyc, e.due);
        check({tag, ".result"}, r, e.res);
        check({tag, ".peak"}, p, e.peak);
      end
      held_r[idx] = r;
      held_p[idx] = p;
    end else begin
      if (pending != 0) begin
        e = (idx == 0) ? q0[0] : q1[0];
        if (cyc >= e.due) begin
          check({tag, ".missing_valid"}, 0, 1);
          if (idx == 0) void'(q0.pop_front());
          else          void'(q1.pop_front());
        end
      end
      check({tag, ".held_result"}, r, held_r[idx]);
      check({tag, ".held_peak"}, p, held_p[idx]);
    end
  endtask

  always @(negedge clk) begin
    mon(0, valid0, result0, int'(peak0));
    mon(1, valid1, result1, int'(peak1));
  end

  task automatic put(input int idx, input logic v, input int val);
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    iv1 = 1'b0;
    if (idx == 0) begin
      iv0 = v;
      d0  = DW'(val);
    end else begin
      iv1 = v;
      d1  = DW'(val);
    end
  endtask

  task automatic expect_at(input int idx, input logic res, input int peak);
    exp_t e;
    e.res  = res;
    e.peak = peak;
    e.due  = cyc + 1;
    if (idx == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic send(input int idx, input int n, input int cars[$], input bit bub,
                      input logic res, input int peak);
    put(idx, 1'b1, n);
    if (n > 10) begin
      expect_at(idx, res, peak);
    end else begin
      for (int i = 0; i < cars.size(); i++) begin
        if (bub) repeat ($urandom_range(0, 2)) put(idx, 1'b0, $urandom_range(0, 15));
        put(idx, 1'b1, cars[i]);
        if (i == cars.size() - 1) expect_at(idx, res, peak);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) put(0, 1'b0, 0);
  endtask

  initial begin
    int c[$];
    reset = 1'b1;
    iv0 = 1'b0; iv1 = 1'b0; d0 = '0; d1 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    c = '{1, 2, 3, 4, 5};             send(0, 5, c, 0, 1'b1, 0);
    c = '{3, 2, 1, 5, 4};             send(0, 5, c, 0, 1'b1, 2);
    c = '{5, 4, 1, 2, 3};             send(0, 5, c, 0, 1'b0, 4);
    c = '{2, 2, 1};                   send(0, 3, c, 0, 1'b0, 1);
    c = {};                           send(0, 11, c, 0, 1'b0, 0);
    c = {};                           send(0, 0, c, 0, 1'b0, 0);
    c = '{1, 2, 2};                   send(0, 3, c, 0, 1'b0, 0);
    c = '{1, 5, 2, 3};                send(0, 4, c, 0, 1'b0, 0);
    c = '{0, 1};                      send(0, 2, c, 0, 1'b0, 0);
    c = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
    send(0, 10, c, 0, 1'b1, 9);
    idle(3);

    c = '{1, 2, 3, 4, 5};             send(0, 5, c, 1, 1'b1, 0);
    c = '{3, 2, 1, 5, 4};             send(0, 5, c, 1, 1'b1, 2);
    c = '{5, 4, 1, 2, 3};             send(0, 5, c, 1, 1'b0, 4);
    idle(3);

    c = '{1, 2};                      send(0, 2, c, 0, 1'b1, 0);
    c = '{2, 1};                      send(0, 2, c, 0, 1'b1, 1);
    idle(3);

    put(0, 1'b1, 5);
    put(0, 1'b1, 1);
    put(0, 1'b1, 2);
    @(posedge clk);
    #1 reset = 1'b1; iv0 = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    idle(2);
    c = '{2, 1};                      send(0, 2, c, 0, 1'b1, 1);
    idle(3);

    c = '{4, 3, 2, 1};                send(1, 4, c, 0, 1'b0, 3);
    c = '{3, 2, 1};                   send(1, 3, c, 0, 1'b1, 2);
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
